// File: rtl/chb_pkg.sv
// Shared defaults and select-decoding helper for the coded-symbol channel buffer.
package chb_pkg;

  localparam int W_DEF     = 2;
  localparam int N_DEF     = 3;
  localparam int DEPTH_DEF = 4;

  // Widest strobe vector the decoder helper accepts.
  localparam int MAX_N = 32;
  localparam int IDX_W = $clog2(MAX_N);

  typedef logic [$clog2(N_DEF)-1:0] bank_idx_t;

  typedef struct packed {
    logic             is_zero;
    logic             is_onehot;
    logic [IDX_W-1:0] index;
  } onehot_t;

  function automatic onehot_t onehot_chk(input logic [MAX_N-1:0] vec);
    onehot_t res;
    int      cnt;
    res = '0;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (vec[i]) begin
        cnt       = cnt + 1;
        res.index = IDX_W'(i);
      end
    end
    res.is_zero   = (cnt == 0);
    res.is_onehot = (cnt == 1);
    return res;
  endfunction

endpackage

// File: rtl/chb_fifo.sv
// Small synchronous FIFO; head is read straight from the register array.
module chb_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/chb_stream.sv
// Bank-select alignment stage feeding a ready/valid symbol FIFO, with
// sticky illegal-select and overflow flags.
module chb_stream
  import chb_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N-1:0]               rd_sel,
  input  logic [N*W-1:0]             sym_in,
  input  logic                       clr,
  output logic [W-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(N)-1:0]       last_bank,
  output logic                       sel_err,
  output logic                       ovf
);

  localparam int BW = $clog2(N);

  logic [MAX_N-1:0] sel_ext;
  onehot_t          chk;
  logic             sel_bad;
  logic             pend;
  logic [BW-1:0]    bank_q;
  logic [W-1:0]     push_data;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic             drop;

  always_comb begin
    sel_ext         = '0;
    sel_ext[N-1:0]  = rd_sel;
    chk             = onehot_chk(sel_ext);
    sel_bad         = en && !chk.is_zero && !chk.is_onehot;
  end

  // Bank data arrives one cycle after its strobe, so the registered index picks the slice.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < N; i++) begin
      if (bank_q == BW'(i)) push_data = sym_in[i*W +: W];
    end
  end

  // Handshake: a symbol transfers on any rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_data holds while out_valid && !out_ready.
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push_ok   = pend && (!full || pop);
  assign drop      = pend && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= 1'b0;
      bank_q    <= '0;
      last_bank <= '0;
      sel_err   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      pend <= en && chk.is_onehot;
      if (en && chk.is_onehot) bank_q <= BW'(chk.index);
      if (push_ok) last_bank <= bank_q;
      if (sel_bad)  sel_err <= 1'b1;
      else if (clr) sel_err <= 1'b0;
      if (drop)     ovf <= 1'b1;
      else if (clr) ovf <= 1'b0;
    end
  end

  chb_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_data),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_chb_stream.sv
// Directed bench for chb_stream: vector table plus multi-cycle sequences with a queue model.
module tb_chb_stream;

  localparam int W     = 2;
  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam logic [N*W-1:0] S_FIX = {2'd2, 2'd1, 2'd3};

  logic           clk;
  logic           rst;
  logic           en;
  logic [N-1:0]   rd_sel;
  logic [N*W-1:0] sym_in;
  logic           clr;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     level;
  logic [1:0]     last_bank;
  logic           sel_err;
  logic           ovf;

  int errors;
  int checks;

  chb_stream #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rd_sel    (rd_sel),
    .sym_in    (sym_in),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .last_bank (last_bank),
    .sel_err   (sel_err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       en;
    logic [2:0] sel;
    logic       clr;
    logic       rdy;
    logic       ev;
    logic [1:0] ed;
    logic [2:0] el;
    logic [1:0] elb;
    logic       se;
    logic       ov;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic e, input logic [2:0] s, input logic c, input logic r,
                              input logic ev, input logic [1:0] ed, input logic [2:0] el,
                              input logic [1:0] elb, input logic se, input logic ov);
    vec_t v;
    v = '{en: e, sel: s, clr: c, rdy: r, ev: ev, ed: ed, el: el, elb: elb, se: se, ov: ov};
    return v;
  endfunction

  // Queue model for the multi-cycle sequences.
  logic [W-1:0] exp_q [$];
  logic         pend_m;
  int           bank_m;
  logic [1:0]   lb_m;
  logic         ovf_m;

  task automatic cyc(input logic e, input logic [2:0] s, input logic r);
    logic pop_m;
    logic full_m;
    en        = e;
    rd_sel    = s;
    clr       = 1'b0;
    out_ready = r;
    sym_in    = N*W'($urandom_range(0, 63));
    pop_m  = (exp_q.size() != 0) && r;
    full_m = (exp_q.size() == DEPTH);
    if (pop_m) void'(exp_q.pop_front());
    if (pend_m) begin
      if (!full_m || pop_m) begin
        exp_q.push_back(sym_in[bank_m*W +: W]);
        lb_m = 2'(bank_m);
      end else begin
        ovf_m = 1'b1;
      end
    end
    pend_m = e && $onehot(s);
    if (pend_m) bank_m = (s == 3'b001) ? 0 : (s == 3'b010) ? 1 : 2;
    @(posedge clk);
    #1;
    chk("seq valid", 32'(out_valid), 32'(exp_q.size() != 0));
    chk("seq level", 32'(level), 32'(exp_q.size()));
    if (exp_q.size() != 0) chk("seq data", 32'(out_data), 32'(exp_q[0]));
    chk("seq last_bank", 32'(last_bank), 32'(lb_m));
    chk("seq ovf", 32'(ovf), 32'(ovf_m));
    chk("seq sel_err", 32'(sel_err), 32'(0));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    en        = 1'b0;
    rd_sel    = '0;
    sym_in    = S_FIX;
    clr       = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_data", 32'(out_data), 32'(0));
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset level", 32'(level), 32'(0));
    chk("reset last_bank", 32'(last_bank), 32'(0));
    chk("reset sel_err", 32'(sel_err), 32'(0));
    chk("reset ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // In-order streaming from banks {2,1,3}
    tbl[0]  = mk(1, 3'b001, 0, 1,  0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 3'b010, 0, 1,  1, 3, 1, 0, 0, 0);
    tbl[2]  = mk(1, 3'b100, 0, 1,  1, 1, 1, 1, 0, 0);
    tbl[3]  = mk(1, 3'b000, 0, 1,  1, 2, 1, 2, 0, 0);
    tbl[4]  = mk(1, 3'b000, 0, 1,  0, 0, 0, 2, 0, 0);
    // Illegal selects, clear, and set-beats-clear
    tbl[5]  = mk(1, 3'b011, 0, 1,  0, 0, 0, 2, 1, 0);
    tbl[6]  = mk(1, 3'b000, 1, 1,  0, 0, 0, 2, 0, 0);
    tbl[7]  = mk(0, 3'b011, 0, 1,  0, 0, 0, 2, 0, 0);
    tbl[8]  = mk(0, 3'b000, 0, 1,  0, 0, 0, 2, 0, 0);
    tbl[9]  = mk(1, 3'b101, 0, 1,  0, 0, 0, 2, 1, 0);
    tbl[10] = mk(1, 3'b110, 1, 1,  0, 0, 0, 2, 1, 0);
    tbl[11] = mk(1, 3'b000, 1, 1,  0, 0, 0, 2, 0, 0);
    // Backpressure: six strobes, two dropped, then drain
    tbl[12] = mk(1, 3'b001, 0, 0,  0, 0, 0, 2, 0, 0);
    tbl[13] = mk(1, 3'b010, 0, 0,  1, 3, 1, 0, 0, 0);
    tbl[14] = mk(1, 3'b100, 0, 0,  1, 3, 2, 1, 0, 0);
    tbl[15] = mk(1, 3'b001, 0, 0,  1, 3, 3, 2, 0, 0);
    tbl[16] = mk(1, 3'b010, 0, 0,  1, 3, 4, 0, 0, 0);
    tbl[17] = mk(1, 3'b100, 0, 0,  1, 3, 4, 0, 0, 1);
    tbl[18] = mk(1, 3'b000, 0, 0,  1, 3, 4, 0, 0, 1);
    tbl[19] = mk(1, 3'b000, 0, 1,  1, 1, 3, 0, 0, 1);
    tbl[20] = mk(1, 3'b000, 0, 1,  1, 2, 2, 0, 0, 1);
    tbl[21] = mk(1, 3'b000, 0, 1,  1, 3, 1, 0, 0, 1);
    tbl[22] = mk(1, 3'b000, 1, 1,  0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      en        = tbl[i].en;
      rd_sel    = tbl[i].sel;
      clr       = tbl[i].clr;
      out_ready = tbl[i].rdy;
      sym_in    = S_FIX;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("row%0d level", i), 32'(level), 32'(tbl[i].el));
      chk($sformatf("row%0d last_bank", i), 32'(last_bank), 32'(tbl[i].elb));
      chk($sformatf("row%0d sel_err", i), 32'(sel_err), 32'(tbl[i].se));
      chk($sformatf("row%0d ovf", i), 32'(ovf), 32'(tbl[i].ov));
    end
    clr = 1'b0;

    pend_m = 1'b0;
    bank_m = 0;
    lb_m   = 2'd0;
    ovf_m  = 1'b0;
    exp_q.delete();

    // Fill to full, then push and pop together for 8 cycles
    for (int k = 0; k < 5; k++) cyc(1'b1, 3'(1 << (k % 3)), 1'b0);
    for (int k = 5; k < 13; k++) begin
      cyc(1'b1, 3'(1 << (k % 3)), 1'b1);
      chk("full-stream level", 32'(level), 32'(DEPTH));
    end
    for (int k = 0; k < 6; k++) cyc(1'b1, 3'b000, 1'b1);

    // Asynchronous reset with three symbols queued
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b1, 3'b010, 1'b0);
    cyc(1'b1, 3'b100, 1'b0);
    cyc(1'b1, 3'b000, 1'b0);
    chk("pre-reset level", 32'(level), 32'(3));
    #2;
    rst = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'(0));
    chk("async level", 32'(level), 32'(0));
    chk("async out_data", 32'(out_data), 32'(0));
    chk("async last_bank", 32'(last_bank), 32'(0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    pend_m = 1'b0;
    lb_m   = 2'd0;
    ovf_m  = 1'b0;
    cyc(1'b1, 3'b010, 1'b1);
    chk("post-reset valid +1", 32'(out_valid), 32'(0));
    cyc(1'b1, 3'b000, 1'b1);
    chk("post-reset valid +2", 32'(out_valid), 32'(1));
    cyc(1'b1, 3'b000, 1'b1);

    // Strobe then drop en: the pending symbol still lands
    cyc(1'b1, 3'b001, 1'b0);
    cyc(1'b0, 3'b010, 1'b0);
    chk("en-drop level", 32'(level), 32'(1));
    cyc(1'b0, 3'b100, 1'b0);
    chk("en-drop level hold", 32'(level), 32'(1));
    cyc(1'b1, 3'b000, 1'b1);
    cyc(1'b1, 3'b000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
